// File: rtl/averaging_sequencer.sv
// Windowed averaging sequencer: clears, collects sample_count samples, publishes the
// floor mean and holds it until the downstream consumer takes it.
module averaging_sequencer #(
    parameter int sample_count         = 4,
    parameter int bitwidth_sample      = 4,
    parameter int bitwidth_accumulator = 6
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       restart,
    input  logic                       sample_valid,
    input  logic [bitwidth_sample-1:0] sample_value,
    output logic                       sample_ready,
    output logic                       clear,
    output logic                       add,
    output logic                       show,
    output logic [bitwidth_sample-1:0] mean_value,
    output logic                       mean_valid,
    input  logic                       mean_ready
);

    localparam int CW = $clog2(sample_count);
    localparam logic [CW-1:0] LAST = CW'(sample_count - 1);

    typedef enum logic [1:0] {CLEAR, COLLECT, SHOW, HOLD} state_t;

    state_t                          state_q, state_d;
    logic [bitwidth_accumulator-1:0] acc_q, acc_d;
    logic [CW-1:0]                   cnt_q, cnt_d;
    logic [bitwidth_sample-1:0]      mean_q, mean_d;
    logic                            mv_q, mv_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= CLEAR;
            acc_q   <= '0;
            cnt_q   <= '0;
            mean_q  <= '0;
            mv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            mean_q  <= mean_d;
            mv_q    <= mv_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        mean_d       = mean_q;
        mv_d         = mv_q;
        sample_ready = 1'b0;
        clear        = 1'b0;
        add          = 1'b0;
        show         = 1'b0;

        case (state_q)
            CLEAR: begin
                // state is forced to CLEAR during reset; keep the strobe quiet until release
                clear   = reset;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = COLLECT;
            end
            COLLECT: begin
                sample_ready = !restart;
                if (sample_valid && !restart) begin
                    add   = 1'b1;
                    acc_d = acc_q + bitwidth_accumulator'(sample_value);
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_d = SHOW;
                    end
                end
            end
            SHOW: begin
                show    = !restart;
                mean_d  = bitwidth_sample'(acc_q >> CW);
                mv_d    = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (mv_q && mean_ready) begin
                    mv_d    = 1'b0;
                    state_d = CLEAR;
                end
            end
            default: state_d = CLEAR;
        endcase

        // restart wins over any accept, publish or handshake in the same cycle
        if (restart) begin
            state_d = CLEAR;
            acc_d   = '0;
            cnt_d   = '0;
            mean_d  = mean_q;
            mv_d    = 1'b0;
        end
    end

    assign mean_value = mean_q;
    assign mean_valid = mv_q;

endmodule

// File: tb/tb_averaging_sequencer.sv
// Self-checking bench: directed vector table, hand-written corner sequences and a
// randomized run, all checked against a window-queue reference model.
module tb_averaging_sequencer;

    localparam int N  = 4;
    localparam int SW = 4;
    localparam int AW = 6;

    logic          clock = 1'b0;
    logic          reset;
    logic          restart;
    logic          sample_valid;
    logic [SW-1:0] sample_value;
    logic          sample_ready;
    logic          clear;
    logic          add;
    logic          show;
    logic [SW-1:0] mean_value;
    logic          mean_valid;
    logic          mean_ready;

    always #5 clock = ~clock;

    averaging_sequencer #(
        .sample_count(N),
        .bitwidth_sample(SW),
        .bitwidth_accumulator(AW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .restart(restart),
        .sample_valid(sample_valid),
        .sample_value(sample_value),
        .sample_ready(sample_ready),
        .clear(clear),
        .add(add),
        .show(show),
        .mean_value(mean_value),
        .mean_valid(mean_valid),
        .mean_ready(mean_ready)
    );

    int checks = 0;
    int fails  = 0;
    int shows  = 0;

    // Reference model: the accepted samples of the open window, plus the pending phases.
    int win[$];
    bit m_clear, m_show, m_mv;
    int m_mean;

    typedef struct {
        logic          r;
        logic          v;
        logic [SW-1:0] d;
        logic          mr;
        logic [8:0]    exp;   // {clear, ready, add, show, mean_valid, mean_value}
    } vec_t;

    vec_t tbl[9];

    function automatic logic [8:0] pack_dut();
        return {clear, sample_ready, add, show, mean_valid, mean_value};
    endfunction

    task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %b required %b (clear,ready,add,show,mv,mean)", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    task automatic model_reset();
        win.delete();
        m_clear = 1'b1;
        m_show  = 1'b0;
        m_mv    = 1'b0;
        m_mean  = 0;
    endtask

    task automatic cycle(input logic r, input logic v, input logic [SW-1:0] d,
                         input logic mr, output logic [8:0] got);
        logic [8:0] exp;
        logic       e_ready, e_add;
        int         s;
        restart      = r;
        sample_valid = v;
        sample_value = d;
        mean_ready   = mr;
        #1;
        e_ready = !m_clear && !m_show && !m_mv && !r;
        e_add   = e_ready && v;
        exp     = {m_clear, e_ready, e_add, m_show && !r, m_mv, SW'(m_mean)};
        got     = pack_dut();
        check("model", got, exp);
        check_int("strobes_exclusive", int'($onehot0({clear, add, show})), 1);
        if (got[5]) shows++;
        @(posedge clock);
        if (r) begin
            win.delete();
            m_clear = 1'b1;
            m_show  = 1'b0;
            m_mv    = 1'b0;
        end else if (m_clear) begin
            m_clear = 1'b0;
            win.delete();
        end else if (m_show) begin
            s = 0;
            foreach (win[i]) s += win[i];
            m_mean = s / N;
            m_mv   = 1'b1;
            m_show = 1'b0;
        end else if (m_mv) begin
            if (mr) begin
                m_mv    = 1'b0;
                m_clear = 1'b1;
            end
        end else if (e_add) begin
            win.push_back(int'(d));
            if (win.size() == N) m_show = 1'b1;
        end
        @(negedge clock);
    endtask

    // Offer each value until it is accepted, optionally idling a cycle after each accept.
    task automatic feed(input int vals[$], input bit gaps);
        logic [8:0] got;
        bit         ok;
        foreach (vals[k]) begin
            ok = 1'b0;
            for (int t = 0; t < 20 && !ok; t++) begin
                cycle(1'b0, 1'b1, SW'(vals[k]), 1'b1, got);
                ok = got[6];
            end
            if (!ok) check_int("feed_accept_timeout", 0, 1);
            if (gaps) cycle(1'b0, 1'b0, '0, 1'b1, got);
        end
    endtask

    task automatic wait_mean(input string name, input int exp, input logic mr);
        logic [8:0] got;
        bit         seen;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            cycle(1'b0, 1'b0, '0, mr, got);
            if (got[4]) begin
                seen = 1'b1;
                check_int(name, int'(got[3:0]), exp);
            end
        end
        if (!seen) check_int({name, "_timeout"}, 0, 1);
    endtask

    task automatic async_reset(input string name);
        #2;
        reset = 1'b0;
        #1;
        check({name, "_immediate"}, pack_dut(), '0);
        model_reset();
        @(posedge clock);
        @(negedge clock);
        #1;
        check({name, "_held"}, pack_dut(), '0);
        reset = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] got;
        int         s0;

        tbl[0] = '{1'b0, 1'b1, 4'd5, 1'b1, 9'b1_0_0_0_0_0000};
        tbl[1] = '{1'b0, 1'b1, 4'd5, 1'b1, 9'b0_1_1_0_0_0000};
        tbl[2] = '{1'b0, 1'b1, 4'd7, 1'b1, 9'b0_1_1_0_0_0000};
        tbl[3] = '{1'b0, 1'b1, 4'd1, 1'b1, 9'b0_1_1_0_0_0000};
        tbl[4] = '{1'b0, 1'b1, 4'd6, 1'b1, 9'b0_1_1_0_0_0000};
        tbl[5] = '{1'b0, 1'b1, 4'd9, 1'b1, 9'b0_0_0_1_0_0000};
        tbl[6] = '{1'b0, 1'b1, 4'd9, 1'b1, 9'b0_0_0_0_1_0100};
        tbl[7] = '{1'b0, 1'b1, 4'd9, 1'b1, 9'b1_0_0_0_0_0100};
        tbl[8] = '{1'b0, 1'b0, 4'd0, 1'b1, 9'b0_1_0_0_0_0100};

        reset        = 1'b0;
        restart      = 1'b0;
        sample_valid = 1'b1;
        sample_value = '0;
        mean_ready   = 1'b1;
        model_reset();
        @(negedge clock);
        #1;
        check("reset_outputs", pack_dut(), '0);
        @(negedge clock);
        #1;
        check("reset_outputs_held", pack_dut(), '0);
        reset = 1'b1;

        // basic window 5,7,1,6 -> 19>>2 = 4
        for (int i = 0; i < 9; i++) begin
            cycle(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].mr, got);
            check($sformatf("table_%0d", i), got, tbl[i].exp);
        end

        // full-scale samples, no wrap
        feed('{15, 15, 15, 15}, 1'b0);
        wait_mean("mean_full_scale", 15, 1'b1);

        // valid gaps between samples
        feed('{2, 4, 6, 8}, 1'b1);
        wait_mean("mean_with_gaps", 5, 1'b1);

        // back-pressure on the mean for 10 cycles
        feed('{9, 3, 4, 0}, 1'b0);
        wait_mean("mean_backpressure", 4, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, 4'd7, 1'b0, got);
            check("hold_stable", got, 9'b0_0_0_0_1_0100);
        end
        cycle(1'b0, 1'b1, 4'd7, 1'b1, got);
        check("hold_handshake", got, 9'b0_0_0_0_1_0100);
        cycle(1'b0, 1'b0, 4'd0, 1'b1, got);
        check("clear_after_handshake", got, 9'b1_0_0_0_0_0100);

        // restart after a partial window, coincident with a valid sample
        s0 = shows;
        feed('{3, 3}, 1'b0);
        cycle(1'b1, 1'b1, 4'd3, 1'b1, got);
        check_int("restart_blocks_ready_add", int'(got[7:6]), 0);
        feed('{1, 1, 1, 1}, 1'b0);
        wait_mean("mean_after_restart", 1, 1'b1);
        check_int("show_count_restart", shows - s0, 1);

        // asynchronous reset mid-collect: window discarded
        feed('{12, 12}, 1'b0);
        s0 = shows;
        async_reset("reset_collect");
        cycle(1'b0, 1'b0, '0, 1'b1, got);
        check("clear_after_reset", got, 9'b1_0_0_0_0_0000);
        feed('{8, 0, 0, 0}, 1'b0);
        wait_mean("mean_after_reset", 2, 1'b1);
        check_int("show_count_reset", shows - s0, 1);

        // asynchronous reset while holding a mean
        feed('{14, 14, 14, 13}, 1'b0);
        wait_mean("mean_before_hold_reset", 13, 1'b0);
        async_reset("reset_hold");
        cycle(1'b0, 1'b0, '0, 1'b0, got);
        check("clear_after_hold_reset", got, 9'b1_0_0_0_0_0000);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) async_reset("reset_random");
            cycle(($urandom_range(31) == 0), ($urandom_range(9) < 7),
                  SW'($urandom), 1'($urandom_range(1)), got);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/averaging_sequencer.md
AVERAGING_SEQUENCER -- requirements
Module: averaging_sequencer

Interface
REQ-001 The block SHALL have parameter sample_count, default 4, meaning samples per mean (power of two, >= 2).
REQ-002 The block SHALL have parameter bitwidth_sample, default 4, meaning sample and mean width.
REQ-003 The block SHALL have parameter bitwidth_accumulator, default 6, meaning running-sum width (>= bitwidth_sample + log2(sample_count)).
REQ-004 clock  input  1  sole clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 restart  input  1  synchronous request to abandon the current window and start a new one.
REQ-007 sample_valid  input  1  upstream offers sample_value.
REQ-008 sample_value  input  bitwidth_sample  unsigned sample.
REQ-009 sample_ready  output  1  block accepts a sample this cycle.
REQ-010 clear  output  1  strobe to downstream averagers: window reset.
REQ-011 add  output  1  strobe to downstream averagers: accumulate current sample.
REQ-012 show  output  1  strobe to downstream averagers: publish mean.
REQ-013 mean_value  output  bitwidth_sample  registered mean of last complete window.
REQ-014 mean_valid  output  1  mean_value holds an unconsumed result.
REQ-015 mean_ready  input  1  downstream consumes mean_value.

Function
REQ-016 The block SHALL implement states CLEAR, COLLECT, SHOW, HOLD.
REQ-017 CLEAR: clear=1, accumulator<=0, count<=0, sample_ready=0; next state COLLECT unconditionally (clear is exactly one cycle).
REQ-018 COLLECT: sample_ready=1; accept when sample_valid && sample_ready.
REQ-019 On accept: add=1 combinationally in the same cycle, accumulator<=accumulator+sample_value (zero-extended), count<=count+1.
REQ-020 add SHALL be 0 in every cycle without an accept.
REQ-021 Accept with count==sample_count-1 SHALL move to SHOW; otherwise remain in COLLECT.
REQ-022 SHOW: show=1 for exactly one cycle, sample_ready=0, mean_value<=accumulator >> log2(sample_count) (floor), mean_valid<=1; next state HOLD.
REQ-023 Latency: last sample accepted in cycle N -> show=1 in N+1 -> mean_valid=1 with new mean_value in N+2.
REQ-024 HOLD: sample_ready=0, mean_value and mean_valid stable until mean_valid && mean_ready; then mean_valid<=0 and next state CLEAR.
REQ-025 mean_valid and mean_value SHALL never change while mean_valid=1 and mean_ready=0, except on restart or reset.
REQ-026 The accumulator SHALL never overflow under REQ-003; no saturation logic.
REQ-027 sample_valid=0 gaps in COLLECT SHALL stall without changing accumulator or count.
REQ-028 restart=1 in any state SHALL force next state CLEAR, mean_valid<=0, discard partial sum; restart dominates a simultaneous accept (sample_ready=0 and add=0 that cycle) and a simultaneous mean handshake.
REQ-029 clear, add, show SHALL be mutually exclusive in every cycle.

Reset
REQ-030 reset=0 SHALL immediately force state CLEAR, accumulator=0, count=0, mean_value=0, mean_valid=0.
REQ-031 While reset=0, add=0, show=0, sample_ready=0, clear=0; first cycle after reset release SHALL be CLEAR with clear=1.
REQ-032 Reset asserted mid-window SHALL discard the window; no show is generated for it.

Verification
REQ-033 Defaults, sample_valid=1 continuously, samples 5,7,1,6, mean_ready=1 -> clear one cycle, add four consecutive cycles, show one cycle, mean_value=4 (19>>2), mean_valid one cycle, then clear again.
REQ-034 Samples 15,15,15,15 -> sum 60 fits 6 bits, mean_value=15, no wrap.
REQ-035 sample_valid toggled 1,0,1,0... with samples 2,4,6,8 -> add only on accept cycles, mean_value=5, count unaffected by gaps.
REQ-036 mean_ready=0 for 10 cycles after mean_valid -> mean_valid and mean_value held, sample_ready=0, no add/clear; mean_ready=1 -> mean_valid drops next cycle, clear follows.
REQ-037 restart pulsed after 2 accepted samples (3,3) then samples 1,1,1,1 -> no show for partial window, final mean_value=1; restart coincident with a valid sample -> add=0 that cycle.
REQ-038 reset pulsed low asynchronously (between clock edges) mid-COLLECT and in HOLD -> all outputs 0 immediately, mean_valid=0, clear=1 on first post-release cycle.
